// File: rtl/syzygy_adc_capture_ctrl.sv
// syzygy_adc_capture_ctrl: encode-clock wake sequencer and fixed-length ADC sample burst capture.
// SYZYGY_ADC_AUTO_SLEEP_EN: gate the encode clock off between bursts and run a WAKE phase on start.
module syzygy_adc_capture_ctrl #(
  parameter int DATA_W      = 12,
  parameter int WAKE_CYCLES = 256,
  parameter int PIPE_LAT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       capture_len,
  input  logic [DATA_W-1:0] adc_data_in,
  output logic              enc_ce,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       sample_count
);
  localparam logic [2:0] IDLE = 3'd0, WAKE = 3'd1, FLUSH = 3'd2, CAPTURE = 3'd3, DONE = 3'd4;
`ifdef SYZYGY_ADC_AUTO_SLEEP_EN
  localparam logic [2:0] START_ST = WAKE;
`else
  localparam logic [2:0] START_ST = FLUSH;
`endif
  logic [2:0] state, state_nx;
  logic [15:0] cnt, len;
  logic wake_end, flush_end, cap_end, accept;
  assign wake_end  = cnt == 16'(WAKE_CYCLES - 1);
  assign flush_end = cnt == 16'(PIPE_LAT - 1);
  assign cap_end   = cnt == len - 16'd1;
  assign accept    = state == IDLE && start && !abort;
  always_comb begin
    state_nx = abort            ? IDLE :
               state == IDLE    ? (start ? START_ST : IDLE) :
               state == WAKE    ? (wake_end ? FLUSH : WAKE) :
               state == FLUSH   ? (flush_end ? (len == 16'd0 ? DONE : CAPTURE) : FLUSH) :
               state == CAPTURE ? (cap_end ? DONE : CAPTURE) : IDLE;
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      len          <= '0;
      enc_ce       <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= state_nx != state ? '0 : cnt + {15'd0, cnt != 16'hFFFF};
      if (accept) begin
        len          <= capture_len;
        overflow     <= 1'b0;
        sample_count <= '0;
      end else if (state == CAPTURE && !abort) begin
        if (sample_ready) sample_count <= sample_count + {15'd0, sample_count != 16'hFFFF};
        else overflow <= 1'b1;
      end
      if (state_nx == CAPTURE) sample_data <= adc_data_in;
      sample_valid <= state_nx == CAPTURE;
      busy         <= state_nx != IDLE;
      done         <= state_nx == DONE;
`ifdef SYZYGY_ADC_AUTO_SLEEP_EN
      enc_ce       <= state_nx inside {WAKE, FLUSH, CAPTURE};
`else
      enc_ce       <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_syzygy_adc_capture_ctrl.sv
// tb_syzygy_adc_capture_ctrl: directed and random bursts checked against an offset-based timeline model.
module tb_syzygy_adc_capture_ctrl;
  localparam int DW = 12, W_C = 4, P = 2;
`ifdef SYZYGY_ADC_AUTO_SLEEP_EN
  localparam int WK = W_C;
  localparam bit SLEEP = 1'b1;
`else
  localparam int WK = 0;
  localparam bit SLEEP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, sample_ready = 1'b1;
  logic [15:0] capture_len = '0;
  logic [DW-1:0] adc_data_in = '0;
  logic enc_ce, sample_valid, busy, done, overflow;
  logic [DW-1:0] sample_data;
  logic [15:0] sample_count;
  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0, mlen = 0, mcount = 0;
  bit active = 0, powered = 0, movf = 0, ramp = 1, rst_seen = 0;
  logic [DW-1:0] mdata = '0;
  always #5 clk = ~clk;
  syzygy_adc_capture_ctrl #(.DATA_W(DW), .WAKE_CYCLES(W_C), .PIPE_LAT(P)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .capture_len(capture_len),
    .adc_data_in(adc_data_in), .enc_ce(enc_ce), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy), .done(done),
    .overflow(overflow), .sample_count(sample_count)
  );
  function automatic bit is_valid(int k);
    return k >= WK + P + 1 && k <= WK + P + mlen;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic tick();
    int k;
    @(posedge clk);
    rst_seen = reset;
    if (reset) begin
      active = 0; powered = 0; mcount = 0; movf = 0; mdata = '0;
    end else begin
      powered = 1;
      k = cyc - t0;
      if (active) begin
        if (is_valid(k) && !abort) begin
          if (sample_ready) mcount++;
          else movf = 1;
        end
        if (abort || k == WK + P + mlen + 1) active = 0;
      end else if (start && !abort) begin
        active = 1; t0 = cyc; mlen = int'(capture_len); mcount = 0; movf = 0;
      end
      if (active && is_valid(cyc + 1 - t0)) mdata = adc_data_in;
    end
    cyc++;
    @(negedge clk);
    k = cyc - t0;
    chk("busy", busy, active);
    chk("sample_valid", sample_valid, active && is_valid(k));
    chk("done", done, active && k == WK + P + mlen + 1);
    chk("enc_ce", enc_ce, SLEEP ? (active && k <= WK + P + mlen) : powered);
    chk("sample_count", sample_count, mcount);
    chk("overflow", overflow, movf);
    if (active && is_valid(k)) chk("sample_data", sample_data, mdata);
    if (rst_seen) chk("sample_data_rst", sample_data, 0);
    adc_data_in = ramp ? DW'(cyc) : DW'($urandom);
  endtask
  initial begin
    repeat (3) tick();
    reset = 0;
    repeat (2) tick();
    capture_len = 16'd5; start = 1; tick(); start = 0; capture_len = 0;
    repeat (14) tick();
    chk("basic_count", sample_count, 5);
    chk("basic_ovf", overflow, 0);
    capture_len = 16'd6; start = 1; tick(); start = 0;
    repeat (14) begin
      sample_ready = !(cyc - t0 == WK + P + 3 || cyc - t0 == WK + P + 4);
      tick();
    end
    sample_ready = 1;
    chk("bp_count", sample_count, 4);
    chk("bp_ovf", overflow, 1);
    capture_len = 16'd0; start = 1; tick(); start = 0;
    chk("clear_count", sample_count, 0);
    chk("clear_ovf", overflow, 0);
    repeat (10) tick();
    chk("len0_count", sample_count, 0);
    capture_len = 16'd10; start = 1; tick(); start = 0;
    repeat (12) begin
      abort = cyc - t0 == WK + P + 2;
      start = cyc - t0 >= WK + 1 && cyc - t0 <= WK + P;
      tick();
    end
    abort = 0; start = 0;
    chk("abort_count", sample_count, 1);
    chk("abort_busy", busy, 0);
    capture_len = 16'd3; start = 1; tick(); start = 0;
    reset = 1; tick(); reset = 0;
    chk("midreset_busy", busy, 0);
    tick();
    start = 1; reset = 1; tick(); start = 0; reset = 0;
    tick();
    chk("start_reset_idle", busy, 0);
    ramp = 0;
    repeat (400) begin
      start = $urandom_range(0, 7) == 0;
      capture_len = 16'($urandom_range(0, 8));
      sample_ready = $urandom_range(0, 3) != 0;
      abort = $urandom_range(0, 40) == 0;
      reset = $urandom_range(0, 150) == 0;
      tick();
    end
    start = 0; abort = 0; reset = 0; sample_ready = 1;
    repeat (20) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/syzygy_adc_capture_ctrl.md
# syzygy_adc_capture_ctrl

Sequencer for the SYZYGY ADC encode path and sample capture. On a host start pulse it enables the ADC encode clock and waits out ADC wake-up and pipeline latency. It then forwards a fixed-length burst of ADC samples to the downstream capture FIFO and reports completion and overflow. It sits between the host register/trigger logic and the encode clock buffer / ADC data input registers.

## Interface
- `DATA_W`, 12: ADC sample width.
- `WAKE_CYCLES`, 256: encode cycles to wait after enabling encode before discarding pipeline data; legal range 1..65535.
- `PIPE_LAT`, 8: ADC pipeline latency plus input register stages, in cycles; these samples are discarded; legal range 1..255.

- `clk`  in  1  ADC sample-domain clock, same clock that drives the encode output.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle capture request; honoured only in IDLE.
- `abort`  in  1  terminates any active sequence.
- `capture_len`  in  16  samples to capture; latched on accepted `start`.
- `adc_data_in`  in  DATA_W  registered ADC data.
- `enc_ce`  out  1  clock enable for the encode clock buffer.
- `sample_data`  out  DATA_W  captured sample.
- `sample_valid`  out  1  `sample_data` valid this cycle.
- `sample_ready`  in  1  FIFO can accept; low means FIFO full.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `overflow`  out  1  sticky; a sample was dropped.
- `sample_count`  out  16  samples accepted by the FIFO in the current or last burst.

## Operation
- States: IDLE, WAKE, FLUSH, CAPTURE, DONE. All outputs are registered.
- IDLE to WAKE on `start`:
  - latch `capture_len`;
  - clear `overflow` and `sample_count`.
- WAKE:
  - `enc_ce`=1;
  - stays for exactly `WAKE_CYCLES` cycles, then goes to FLUSH.
- FLUSH:
  - stays for exactly `PIPE_LAT` cycles;
  - `sample_valid`=0 throughout.
- CAPTURE:
  - stays for exactly the latched `capture_len` cycles;
  - each cycle: `sample_valid`=1 and `sample_data`=`adc_data_in`.
  - if `sample_ready`=1, `sample_count`++;
  - if `sample_ready`=0, the sample is dropped and `overflow` is set. The ADC cannot stall, so the burst length is unchanged.
- Latched `capture_len`=0: FLUSH goes directly to DONE, with no `sample_valid`.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in WAKE, FLUSH, CAPTURE and DONE.
- `abort` in any non-IDLE state: IDLE on the next cycle.
  - `sample_valid` drops;
  - no `done` pulse;
  - `overflow` and `sample_count` hold their values.
- `start` and `abort` in the same IDLE cycle: `abort` wins and `start` is ignored.
- `start` outside IDLE is ignored.
- Counters are 16-bit and saturate at 0xFFFF; no wrap.

## Timing
- Reset values: `enc_ce`=0, `sample_valid`=0, `sample_data`=0, `busy`=0, `done`=0, `overflow`=0, `sample_count`=0; state IDLE.
- A `reset` asserted mid-sequence takes effect at the next edge. It overrides `start` and `abort`.
- `start` sampled at edge T:
  - WAKE from T+1;
  - FLUSH from T+1+WAKE_CYCLES;
  - first `sample_valid` at T+1+WAKE_CYCLES+PIPE_LAT;
  - last `sample_valid` at T+WAKE_CYCLES+PIPE_LAT+capture_len;
  - `done` on the following cycle;
  - IDLE, and `start` accepted again, one cycle after `done`.
- `sample_data` lags `adc_data_in` by 1 cycle.
- `sample_count` and `overflow` are updated in the cycle after the sample they account for.

## Configuration
- Macro: `SYZYGY_ADC_AUTO_SLEEP_EN`.
- Defined:
  - `enc_ce`=0 in IDLE and DONE; `enc_ce`=1 in WAKE, FLUSH and CAPTURE;
  - the ADC idles between bursts to save power.
- Undefined:
  - `enc_ce` is 0 during reset and 1 from the first cycle after reset deassertion, and stays 1;
  - WAKE is skipped, so IDLE goes to FLUSH on `start`;
  - all latencies lose the `WAKE_CYCLES` term.

## Test plan
- Bench parameters: WAKE_CYCLES=4, PIPE_LAT=2, macro defined.
  - Scenario: `start` at T with `capture_len`=5, `sample_ready`=1.
  - Required: `enc_ce` 1 over T+1..T+11; `sample_valid` at T+7..T+11 carrying the ramp on `adc_data_in`; `done` at T+12; `sample_count`=5; `overflow`=0.
- Backpressure:
  - Stimulus: `capture_len`=6, `sample_ready` low for the 3rd and 4th samples.
  - Required: exactly 6 valid cycles, `sample_count`=4, `overflow`=1. The next `start` clears both.
- `capture_len`=0:
  - Required: `done` at T+7 with no `sample_valid`; `sample_count`=0.
- Abort and ignored start:
  - Stimulus: `abort` at the 2nd CAPTURE cycle of a 10-sample burst.
  - Required: IDLE and `sample_valid`=0 next cycle; no `done`; `sample_count`=1; `enc_ce`=0.
  - A `start` issued during FLUSH is ignored.
- Reset mid-sequence:
  - Stimulus: `reset` asserted during WAKE.
  - Required: all outputs at reset values the next cycle.
  - `start` and `reset` in the same cycle: remains IDLE.
- Macro undefined:
  - Required: `enc_ce`=1 one cycle after reset release and it stays 1.
  - `start` at T with `capture_len`=3: `sample_valid` at T+3..T+5, `done` at T+6.
